// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer: FSM state encoding,
// retry / lock-loss counter widths and a small constant helper.
package pll_seq_pkg;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef enum logic [2:0] {
    PLLRST    = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } seq_state_t;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with synchronous active-high reset; used for any
// asynchronous input entering the reference clock domain.
module sync2 (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL RESETB / system reset sequencer with lock timeout, bounded retries and
// lock-loss re-sequencing. Define PLL_SEQ_LOCK_LOSS_COUNT_EN to build the lock-loss counter.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 12000,
  parameter int STABLE_CYCLES = 1200,
  parameter int RETRY_LIMIT   = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retries,
  output logic [7:0] lock_loss_count
);

  localparam int CNT_MAX = max_of4(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, RETRY_LIMIT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(RETRY_LIMIT);

  seq_state_t         state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic [RETRY_W-1:0] retries_nx;
  logic               lock_s;

  sync2 u_lock_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (locked),
    .q        (lock_s)
  );

  always_comb begin
    state_nx   = state;
    retries_nx = retries;
    case (state)
      PLLRST: begin
        if (cnt == RST_LAST) state_nx = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still counts as a successful lock.
        if (lock_s) begin
          state_nx = STABLE;
        end else if (cnt == TMO_LAST) begin
          retries_nx = retries + RETRY_W'(1);
          state_nx   = (retries_nx == RETRY_MAX) ? FAULT : PLLRST;
        end
      end
      STABLE: begin
        if (!lock_s)               state_nx = WAIT_LOCK;
        else if (cnt == STB_LAST)  state_nx = RUN;
      end
      RUN: begin
        if (!lock_s) begin
          state_nx   = PLLRST;
          retries_nx = '0;
        end
      end
      FAULT:   state_nx = FAULT;
      default: state_nx = PLLRST;
    endcase
    if (restart) begin
      state_nx   = PLLRST;
      retries_nx = '0;
    end
    cnt_clr = restart || (state_nx != state);
  end

  // Outputs are decoded from the next state so they switch on the entry edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= PLLRST;
      cnt        <= '0;
      retries    <= '0;
      pll_resetb <= 1'b0;
      sys_reset  <= 1'b1;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_clr ? '0 : cnt + CNT_W'(1);
      retries    <= retries_nx;
      pll_resetb <= (state_nx == WAIT_LOCK) || (state_nx == STABLE) || (state_nx == RUN);
      sys_reset  <= (state_nx != RUN);
      ready      <= (state_nx == RUN);
      fault      <= (state_nx == FAULT);
    end
  end

`ifdef PLL_SEQ_LOCK_LOSS_COUNT_EN
  logic [LOSS_W-1:0] loss_cnt;
  logic              loss_hit;

  assign loss_hit = (state == RUN) && !lock_s && !restart;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (loss_hit && (loss_cnt != {LOSS_W{1'b1}})) begin
      loss_cnt <= loss_cnt + LOSS_W'(1);
    end
  end

  assign lock_loss_count = loss_cnt;
`else
  assign lock_loss_count = 8'd0;
`endif

endmodule
